// File: rtl/max_spi_master.sv
// max_spi_master
//   Byte-oriented SPI master (mode 0, MSB first) for the MAX3421E USB
//   controller. It runs one chip-select burst per sequence of bytes that
//   ends with tx_last.
//
//   Handshake: a byte moves across the tx interface on any rising clk edge
//   where tx_valid and tx_ready are both high. tx_data and tx_last are
//   sampled only on that edge. The source must hold tx_valid, tx_data and
//   tx_last stable until that edge. rx_valid is a one-cycle pulse with no
//   back-pressure.
//
//   Parameters:
//     CLK_DIV      clk cycles per SCLK half-period (2..255)
//   Optional feature macro:
//     MAX_SPI_INT_SYNC_EN  enables the INT synchronizer/edge detector
//
//   Ports:
//     clk, rst_n            system clock, async active-low reset
//     tx_valid/tx_data/tx_last/tx_ready   byte input stream
//     rx_valid/rx_data      received byte, one-cycle pulse
//     busy                  SS asserted or deselect gap running
//     spi_ss_n/spi_sclk/spi_mosi/spi_miso SPI pins
//     max_int, int_pulse    MAX3421E INT pin and its falling-edge pulse
//     dbg_state_o           current FSM state, for observation only
module max_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_ss_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  input  logic       max_int,
  output logic       int_pulse,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, GAP, TRAIL, DESEL} state_e;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  tog_q, tog_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        last_q, last_d;
  logic        pend_q, pend_d;
  logic        sclk_q, sclk_d;
  logic        ss_n_q, ss_n_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rdy_en_q;
  logic        hs;
  logic        cnt_wrap;
  logic [7:0]  cnt_inc;

  assign hs = tx_valid & tx_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      tog_q      <= 4'd0;
      tx_sh_q    <= 8'd0;
      rx_sh_q    <= 8'd0;
      last_q     <= 1'b0;
      pend_q     <= 1'b0;
      sclk_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tog_q      <= tog_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      sclk_q     <= sclk_d;
      ss_n_q     <= ss_n_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      // Holds tx_ready low for the first cycle after reset release.
      rdy_en_q   <= 1'b1;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tog_d      = tog_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    last_d     = last_q;
    pend_d     = pend_q;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    cnt_wrap   = (cnt_q == DIV_M1);
    cnt_inc    = cnt_wrap ? 8'd0 : cnt_q + 8'd1;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = LEAD;
          ss_n_d  = 1'b0;
          tx_sh_d = tx_data;
          last_d  = tx_last;
          cnt_d   = 8'd0;
        end
      end
      LEAD: begin
        cnt_d = cnt_inc;
        if (cnt_wrap) state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_inc;
        if (cnt_wrap) begin
          sclk_d = ~sclk_q;
          tog_d  = tog_q + 4'd1;  // wraps to 0 after the 16th toggle
          if (!sclk_q) begin
            rx_sh_d = {rx_sh_q[6:0], spi_miso};
          end else if (tog_q != 4'd15) begin
            // MOSI is tx_sh_q[7]; the 8th falling edge leaves bit 0 in place.
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
          if (tog_q == 4'd15) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
            state_d    = last_q ? TRAIL : GAP;
          end
        end
      end
      GAP: begin
        // pend_q marks a byte already accepted and waiting its setup half-period.
        if (!pend_q) begin
          if (hs) begin
            pend_d  = 1'b1;
            tx_sh_d = tx_data;
            last_d  = tx_last;
            cnt_d   = 8'd0;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_wrap) begin
            pend_d  = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      TRAIL: begin
        cnt_d = cnt_inc;
        if (cnt_wrap) begin
          ss_n_d  = 1'b1;
          state_d = DESEL;
        end
      end
      DESEL: begin
        cnt_d = cnt_inc;
        if (cnt_wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    tx_ready = rdy_en_q & ((state_q == IDLE) | ((state_q == GAP) & ~pend_q));
    busy     = (state_q != IDLE);
  end

  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign spi_ss_n    = ss_n_q;
  assign spi_sclk    = sclk_q;
  assign spi_mosi    = tx_sh_q[7];
  assign dbg_state_o = state_q;

`ifdef MAX_SPI_INT_SYNC_EN
  // INT is active-low; flops idle high so reset release gives no pulse.
  logic int_s1_q, int_s2_q, int_s3_q, int_pulse_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_s1_q    <= 1'b1;
      int_s2_q    <= 1'b1;
      int_s3_q    <= 1'b1;
      int_pulse_q <= 1'b0;
    end else begin
      int_s1_q    <= max_int;
      int_s2_q    <= int_s1_q;
      int_s3_q    <= int_s2_q;
      int_pulse_q <= int_s3_q & ~int_s2_q;
    end
  end
  assign int_pulse = int_pulse_q;
`else
  logic unused_max_int;
  assign unused_max_int = max_int;
  assign int_pulse      = 1'b0;
`endif

endmodule

// File: tb/tb_max_spi_master.sv
// tb_max_spi_master
//   Bench for max_spi_master with CLK_DIV=4. A SPI slave model returns
//   queued MISO bytes and records MOSI bits at each SCLK rising edge.
//   Monitors record handshake, rx_valid, SS rise and int_pulse times in
//   clk-edge units. Scenario tasks compare these against values derived
//   from the protocol timing rules.
module tb_max_spi_master;
  localparam int DIV = 4;
  localparam int TO  = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_last = 1'b0;
  logic       spi_miso = 1'b0;
  logic       max_int = 1'b1;
  logic       tx_ready, rx_valid, busy, spi_ss_n, spi_sclk, spi_mosi, int_pulse;
  logic [7:0] rx_data;
  logic [2:0] dbg_state;

  int total = 0;
  int passed = 0;

  max_spi_master #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_last(tx_last), .tx_ready(tx_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .busy(busy), .spi_ss_n(spi_ss_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .max_int(max_int),
    .int_pulse(int_pulse), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitors ----------------
  int         hs_t[$];
  logic [7:0] rx_got[$];
  int         rx_t[$];
  int         ss_rise_t[$];
  int         int_t[$];
  logic       prev_ss = 1'b1;

  // At a negedge, cyc is the index of the last rising edge.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) hs_t.push_back(cyc + 1);
    if (rx_valid) begin
      rx_got.push_back(rx_data);
      rx_t.push_back(cyc);
    end
    if (spi_ss_n && !prev_ss) ss_rise_t.push_back(cyc);
    prev_ss = spi_ss_n;
    if (int_pulse) int_t.push_back(cyc);
  end

  // ---------------- SPI slave model ----------------
  int         sr_cnt = 0;
  logic       mosi_bits[$];
  logic [7:0] miso_bytes[$];
  int         slv_base = 0;
  int         slv_gen = 0;

  always @(posedge spi_sclk) begin
    mosi_bits.push_back(spi_mosi);
    sr_cnt++;
  end

  // MISO presents bit (7 - n%8) of byte n/8, n = rising edges since load.
  always @(sr_cnt or slv_gen) begin
    int idx;
    idx = sr_cnt - slv_base;
    if (idx >= 0 && (idx / 8) < miso_bytes.size())
      spi_miso = miso_bytes[idx / 8][7 - (idx % 8)];
    else
      spi_miso = 1'b0;
  end

  task automatic load_slave(input logic [7:0] b[$]);
    miso_bytes = b;
    slv_base   = sr_cnt;
    slv_gen++;
  endtask

  function automatic logic [7:0] mosi_byte(input int base);
    logic [7:0] b;
    b = 8'd0;
    for (int i = 0; i < 8; i++)
      b = {b[6:0], (base + i < mosi_bits.size()) ? mosi_bits[base + i] : 1'bx};
    return b;
  endfunction

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_byte(input logic [7:0] d, input logic l, output bit ok);
    ok       = 1'b0;
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = l;
    for (int i = 0; i < TO; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    tx_last  = 1'($urandom);
  endtask

  task automatic wait_ss(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TO; i++) begin
      if (ss_rise_t.size() >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (2 * DIV + 2) @(negedge clk);
  endtask

  task automatic wait_rx(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TO; i++) begin
      if (rx_got.size() >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({spi_ss_n, spi_sclk, spi_mosi, tx_ready, rx_valid, busy, int_pulse} !== 7'b1000000)
      $display("FAIL reset_outputs got ss,sclk,mosi,rdy,rxv,busy,int=%b exp=1000000",
               {spi_ss_n, spi_sclk, spi_mosi, tx_ready, rx_valid, busy, int_pulse});
    else passed++;
    total++;
    if (rx_data !== 8'h00) $display("FAIL reset_rx_data got=%h exp=00", rx_data);
    else passed++;
    rst_n = 1'b1;
    #1;
    total++;
    if (tx_ready !== 1'b0) $display("FAIL reset_ready_early got=%b exp=0", tx_ready);
    else passed++;
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1) $display("FAIL reset_ready_rise got=%b exp=1", tx_ready);
    else passed++;
  endtask

  task automatic test_single();
    logic [7:0] mq[$];
    int rb, mb, sb, hb, sr0;
    bit ok1, ok2;
    mq.push_back(8'h3C);
    load_slave(mq);
    rb = rx_got.size(); mb = mosi_bits.size(); sb = ss_rise_t.size();
    hb = hs_t.size(); sr0 = sr_cnt;
    send_byte(8'hA5, 1'b1, ok1);
    total++;
    if ({ok1, spi_ss_n, busy, tx_ready} !== 4'b1010)
      $display("FAIL single_start got ok,ss,busy,rdy=%b exp=1010", {ok1, spi_ss_n, busy, tx_ready});
    else passed++;
    wait_ss(sb + 1, ok2);
    total++;
    if (ok2 !== 1'b1) $display("FAIL single_ss_timeout got=%b exp=1", ok2);
    else passed++;
    total++;
    if (mosi_byte(mb) !== 8'hA5) $display("FAIL single_mosi got=%h exp=a5", mosi_byte(mb));
    else passed++;
    total++;
    if (rx_got.size() - rb !== 1) $display("FAIL single_rx_count got=%0d exp=1", rx_got.size() - rb);
    else passed++;
    total++;
    if (rx_got[rb] !== 8'h3C) $display("FAIL single_rx_data got=%h exp=3c", rx_got[rb]);
    else passed++;
    total++;
    if (rx_t[rb] - hs_t[hb] !== 17 * DIV)
      $display("FAIL single_latency got=%0d exp=%0d", rx_t[rb] - hs_t[hb], 17 * DIV);
    else passed++;
    total++;
    if (ss_rise_t[sb] - rx_t[rb] !== DIV)
      $display("FAIL single_trail got=%0d exp=%0d", ss_rise_t[sb] - rx_t[rb], DIV);
    else passed++;
    total++;
    if (sr_cnt - sr0 !== 8) $display("FAIL single_sclk_rises got=%0d exp=8", sr_cnt - sr0);
    else passed++;
    total++;
    if ({spi_ss_n, spi_sclk, busy, tx_ready} !== 4'b1001)
      $display("FAIL single_idle got ss,sclk,busy,rdy=%b exp=1001", {spi_ss_n, spi_sclk, busy, tx_ready});
    else passed++;
  endtask

  logic [7:0] bt_q[$];
  logic [7:0] bm_q[$];

  task automatic test_burst(input string name);
    int rb, mb, sb, hb, sr0, n, bad_hs;
    bit ok;
    n = bt_q.size();
    load_slave(bm_q);
    rb = rx_got.size(); mb = mosi_bits.size(); sb = ss_rise_t.size();
    hb = hs_t.size(); sr0 = sr_cnt; bad_hs = 0;
    for (int i = 0; i < n; i++) begin
      send_byte(bt_q[i], (i == n - 1), ok);
      if (!ok) bad_hs++;
    end
    wait_ss(sb + 1, ok);
    total++;
    if ({bad_hs, ok} !== {32'd0, 1'b1})
      $display("FAIL %s_handshake got bad=%0d ss_ok=%b exp bad=0 ss_ok=1", name, bad_hs, ok);
    else passed++;
    total++;
    if (rx_got.size() - rb !== n) $display("FAIL %s_rx_count got=%0d exp=%0d", name, rx_got.size() - rb, n);
    else passed++;
    total++;
    if (ss_rise_t.size() - sb !== 1)
      $display("FAIL %s_ss_low got rises=%0d exp=1", name, ss_rise_t.size() - sb);
    else passed++;
    total++;
    if (sr_cnt - sr0 !== 8 * n) $display("FAIL %s_sclk_rises got=%0d exp=%0d", name, sr_cnt - sr0, 8 * n);
    else passed++;
    for (int i = 0; i < n; i++) begin
      total++;
      if (rx_got[rb + i] !== bm_q[i]) $display("FAIL %s_rx[%0d] got=%h exp=%h", name, i, rx_got[rb + i], bm_q[i]);
      else passed++;
      total++;
      if (mosi_byte(mb + 8 * i) !== bt_q[i])
        $display("FAIL %s_mosi[%0d] got=%h exp=%h", name, i, mosi_byte(mb + 8 * i), bt_q[i]);
      else passed++;
      total++;
      if (rx_t[rb + i] - hs_t[hb + i] !== 17 * DIV)
        $display("FAIL %s_latency[%0d] got=%0d exp=%0d", name, i, rx_t[rb + i] - hs_t[hb + i], 17 * DIV);
      else passed++;
    end
  endtask

  task automatic test_gap_stall();
    logic [7:0] mq[$];
    logic [7:0] b1, b2;
    int rb, mb, sb, hb, bad;
    bit ok1, ok2, ok3, ok4;
    b1 = 8'($urandom); b2 = 8'($urandom);
    mq.push_back(8'($urandom)); mq.push_back(8'($urandom));
    load_slave(mq);
    rb = rx_got.size(); mb = mosi_bits.size(); sb = ss_rise_t.size(); hb = hs_t.size();
    send_byte(b1, 1'b0, ok1);
    wait_rx(rb + 1, ok2);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({spi_ss_n, spi_sclk, tx_ready, rx_valid} !== 4'b0010) bad++;
      tx_data = 8'($urandom);
      tx_last = 1'($urandom);
    end
    total++;
    if ({ok1, ok2, bad} !== {1'b1, 1'b1, 32'd0})
      $display("FAIL gap_hold got ok=%b%b bad_cycles=%0d exp ok=11 bad_cycles=0", ok1, ok2, bad);
    else passed++;
    send_byte(b2, 1'b1, ok3);
    wait_ss(sb + 1, ok4);
    total++;
    if ({ok3, ok4, 32'(ss_rise_t.size() - sb)} !== {1'b1, 1'b1, 32'd1})
      $display("FAIL gap_end got ok=%b%b ss_rises=%0d exp ok=11 ss_rises=1", ok3, ok4, ss_rise_t.size() - sb);
    else passed++;
    total++;
    if ({rx_got[rb], rx_got[rb + 1]} !== {mq[0], mq[1]})
      $display("FAIL gap_rx got=%h%h exp=%h%h", rx_got[rb], rx_got[rb + 1], mq[0], mq[1]);
    else passed++;
    total++;
    if ({mosi_byte(mb), mosi_byte(mb + 8)} !== {b1, b2})
      $display("FAIL gap_mosi got=%h%h exp=%h%h", mosi_byte(mb), mosi_byte(mb + 8), b1, b2);
    else passed++;
    total++;
    if (rx_t[rb + 1] - hs_t[hb + 1] !== 17 * DIV)
      $display("FAIL gap_latency got=%0d exp=%0d", rx_t[rb + 1] - hs_t[hb + 1], 17 * DIV);
    else passed++;
  endtask

  task automatic test_reset_abort();
    logic [7:0] mq[$];
    logic [7:0] b;
    int rb, mb, sb, sr0, reached;
    bit ok1, ok2;
    mq.push_back(8'($urandom));
    load_slave(mq);
    sr0 = sr_cnt; rb = rx_got.size();
    send_byte(8'($urandom), 1'b1, ok1);
    reached = 0;
    for (int i = 0; i < TO; i++) begin
      if (sr_cnt - sr0 >= 4) begin
        reached = 1;
        break;
      end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ok1, 1'(reached), spi_ss_n, spi_sclk, busy, tx_ready} !== 6'b111000)
      $display("FAIL abort_immediate got ok,bit4,ss,sclk,busy,rdy=%b exp=111000",
               {ok1, 1'(reached), spi_ss_n, spi_sclk, busy, tx_ready});
    else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20 * DIV) @(negedge clk);
    total++;
    if (rx_got.size() !== rb) $display("FAIL abort_no_rx got=%0d exp=%0d", rx_got.size() - rb, 0);
    else passed++;
    // Fresh transfer after the abort.
    mq.delete();
    mq.push_back(8'($urandom));
    load_slave(mq);
    b = 8'($urandom);
    rb = rx_got.size(); mb = mosi_bits.size(); sb = ss_rise_t.size();
    send_byte(b, 1'b1, ok1);
    wait_ss(sb + 1, ok2);
    total++;
    if ({ok1, ok2, 32'(rx_got.size() - rb)} !== {1'b1, 1'b1, 32'd1})
      $display("FAIL abort_next_done got ok=%b%b rx=%0d exp ok=11 rx=1", ok1, ok2, rx_got.size() - rb);
    else passed++;
    total++;
    if ({rx_got[rb], mosi_byte(mb)} !== {mq[0], b})
      $display("FAIL abort_next_data got rx=%h mosi=%h exp rx=%h mosi=%h", rx_got[rb], mosi_byte(mb), mq[0], b);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] mq[$];
    logic [7:0] b1, b2;
    int rb, mb, sb, hb;
    bit ok1, ok2, ok3;
    b1 = 8'($urandom); b2 = 8'($urandom);
    mq.push_back(8'($urandom)); mq.push_back(8'($urandom));
    load_slave(mq);
    rb = rx_got.size(); mb = mosi_bits.size(); sb = ss_rise_t.size(); hb = hs_t.size();
    send_byte(b1, 1'b1, ok1);
    send_byte(b2, 1'b1, ok2);
    wait_ss(sb + 2, ok3);
    total++;
    if ({ok1, ok2, ok3} !== 3'b111) $display("FAIL b2b_done got=%b exp=111", {ok1, ok2, ok3});
    else passed++;
    total++;
    if (hs_t[hb + 1] - rx_t[rb] !== 2 * DIV + 1)
      $display("FAIL b2b_ready_gap got=%0d exp=%0d", hs_t[hb + 1] - rx_t[rb], 2 * DIV + 1);
    else passed++;
    total++;
    if (hs_t[hb + 1] - ss_rise_t[sb] < DIV)
      $display("FAIL b2b_ss_high got=%0d exp>=%0d", hs_t[hb + 1] - ss_rise_t[sb], DIV);
    else passed++;
    total++;
    if ({rx_got[rb], rx_got[rb + 1], mosi_byte(mb), mosi_byte(mb + 8)} !== {mq[0], mq[1], b1, b2})
      $display("FAIL b2b_data got rx=%h%h mosi=%h%h exp rx=%h%h mosi=%h%h", rx_got[rb], rx_got[rb + 1],
               mosi_byte(mb), mosi_byte(mb + 8), mq[0], mq[1], b1, b2);
    else passed++;
  endtask

  task automatic test_int();
    int ib, c;
    ib = int_t.size();
`ifdef MAX_SPI_INT_SYNC_EN
    @(negedge clk);
    c = cyc;
    max_int = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (int_t.size() - ib !== 1) $display("FAIL int_count got=%0d exp=1", int_t.size() - ib);
    else passed++;
    total++;
    if (int_t[ib] - c !== 3) $display("FAIL int_delay got=%0d exp=3", int_t[ib] - c);
    else passed++;
    max_int = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (int_t.size() - ib !== 1) $display("FAIL int_release got=%0d exp=1", int_t.size() - ib);
    else passed++;
`else
    c = 0;
    for (int i = 0; i < 30; i++) begin
      max_int = 1'($urandom);
      @(negedge clk);
    end
    max_int = 1'b1;
    total++;
    if (int_t.size() - ib !== c) $display("FAIL int_tied got=%0d exp=0", int_t.size() - ib);
    else passed++;
`endif
  endtask

  // ---------------- sequence ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    bt_q = {8'h11, 8'h22, 8'h33};
    bm_q = {8'h5A, 8'hC3, 8'h0F};
    test_burst("burst_fixed");
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(2, 4);
      bt_q.delete();
      bm_q.delete();
      for (int i = 0; i < n; i++) begin
        bt_q.push_back(8'($urandom));
        bm_q.push_back(8'($urandom));
      end
      test_burst("burst_rand");
    end
    test_gap_stall();
    test_reset_abort();
    test_back_to_back();
    test_int();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
